// File: rtl/winner_search.sv
// Winner search: scans the nodes of one class, one per cycle, and reports the
// nearest (winner) and second-nearest (runner) node to a query vector by
// squared Euclidean distance, plus whether the winner lies within its own
// threshold.

package winner_search_pkg;
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } RD_WR_T;
endpackage

module winner_search
  import winner_search_pkg::*;
#(
  parameter int MAX_NODES = 8,
  parameter int VEC_LEN   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic signed [31:0]       class_i,
  input  logic signed [31:0]       n_nodes_i,
  input  logic [VEC_LEN-1:0][31:0] X_i,
  input  logic [VEC_LEN-1:0][31:0] mem_W_i,
  input  logic signed [31:0]       mem_Th_i,
  output logic signed [31:0]       mem_class_o,
  output logic signed [31:0]       mem_node_o,
  output RD_WR_T                   mem_RD_WR_c,
  output logic                     mem_X_c,
  output logic                     mem_C_c,
  output logic                     mem_W_c,
  output logic                     mem_T_c,
  output logic                     mem_M_c,
  output logic                     busy,
  output logic                     done,
  output logic signed [31:0]       winner_o,
  output logic signed [31:0]       runner_o,
  output logic [63:0]              winner_dist_o,
  output logic [63:0]              runner_dist_o,
  output logic                     within_th_o,
  output logic                     empty_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [63:0] DIST_MAX = '1;

  state_t                     state_q, state_d;
  logic signed [31:0]         class_q, class_d;
  logic [VEC_LEN-1:0][31:0]   x_q, x_d;
  logic [31:0]                n_q, n_d;
  logic [31:0]                idx_q, idx_d;
  logic [63:0]                best_dist_q, best_dist_d;
  logic [63:0]                second_dist_q, second_dist_d;
  logic signed [31:0]         best_idx_q, best_idx_d;
  logic signed [31:0]         second_idx_q, second_idx_d;
  logic signed [31:0]         best_th_q, best_th_d;
  logic signed [31:0]         winner_q, winner_d;
  logic signed [31:0]         runner_q, runner_d;
  logic [63:0]                winner_dist_q, winner_dist_d;
  logic [63:0]                runner_dist_q, runner_dist_d;
  logic                       within_th_q, within_th_d;
  logic                       empty_q, empty_d;

  logic [31:0]                n_clamped;
  logic [32:0]                diff;
  logic signed [65:0]         diff_ext;
  logic [65:0]                square;
  logic [66:0]                acc_sum;
  logic [63:0]                node_dist;
  logic                       closer_than_best;
  logic                       closer_than_second;

  // Requested node count, negative treated as empty and capped at MAX_NODES.
  always_comb begin
    n_clamped = '0;
    if (n_nodes_i < 0) begin
      n_clamped = '0;
    end else if (n_nodes_i > 32'(MAX_NODES)) begin
      n_clamped = 32'(MAX_NODES);
    end else begin
      n_clamped = $unsigned(n_nodes_i);
    end
  end

  // Saturating squared distance between latched query and addressed node.
  always_comb begin
    diff      = '0;
    diff_ext  = '0;
    square    = '0;
    acc_sum   = '0;
    node_dist = '0;
    for (int k = 0; k < VEC_LEN; k++) begin
      diff      = {x_q[k][31], x_q[k]} - {mem_W_i[k][31], mem_W_i[k]};
      diff_ext  = {{33{diff[32]}}, diff};
      square    = diff_ext * diff_ext;
      acc_sum   = {3'b000, node_dist} + {1'b0, square};
      node_dist = (acc_sum[66:64] != 3'b000) ? DIST_MAX : acc_sum[63:0];
    end
    closer_than_best   = node_dist < best_dist_q;
    closer_than_second = node_dist < second_dist_q;
  end

  // Next-state, tracking updates and memory/handshake outputs.
  always_comb begin
    state_d       = state_q;
    class_d       = class_q;
    x_d           = x_q;
    n_d           = n_q;
    idx_d         = idx_q;
    best_dist_d   = best_dist_q;
    second_dist_d = second_dist_q;
    best_idx_d    = best_idx_q;
    second_idx_d  = second_idx_q;
    best_th_d     = best_th_q;
    winner_d      = winner_q;
    runner_d      = runner_q;
    winner_dist_d = winner_dist_q;
    runner_dist_d = runner_dist_q;
    within_th_d   = within_th_q;
    empty_d       = empty_q;
    mem_class_o   = '0;
    mem_node_o    = '0;
    mem_RD_WR_c   = READ;
    mem_X_c       = 1'b0;
    mem_C_c       = 1'b0;
    mem_W_c       = 1'b0;
    mem_T_c       = 1'b0;
    mem_M_c       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          class_d       = class_i;
          x_d           = X_i;
          n_d           = n_clamped;
          idx_d         = '0;
          best_dist_d   = DIST_MAX;
          second_dist_d = DIST_MAX;
          best_idx_d    = -32'sd1;
          second_idx_d  = -32'sd1;
          best_th_d     = '0;
          if (n_clamped != 32'd0) begin
            state_d = SCAN;
          end else begin
            state_d       = FIN;
            winner_d      = -32'sd1;
            runner_d      = -32'sd1;
            winner_dist_d = DIST_MAX;
            runner_dist_d = DIST_MAX;
            within_th_d   = 1'b0;
            empty_d       = 1'b1;
          end
        end
      end

      SCAN: begin
        busy        = 1'b1;
        mem_W_c     = 1'b1;
        mem_T_c     = 1'b1;
        mem_node_o  = $signed(idx_q);
        mem_class_o = class_q;
        if (closer_than_best) begin
          second_dist_d = best_dist_q;
          second_idx_d  = best_idx_q;
          best_dist_d   = node_dist;
          best_idx_d    = $signed(idx_q);
          best_th_d     = mem_Th_i;
        end else if (closer_than_second) begin
          second_dist_d = node_dist;
          second_idx_d  = $signed(idx_q);
        end
        idx_d = idx_q + 32'd1;
        if (idx_q == n_q - 32'd1) begin
          state_d       = FIN;
          winner_d      = best_idx_d;
          runner_d      = second_idx_d;
          winner_dist_d = best_dist_d;
          runner_dist_d = second_dist_d;
          within_th_d   = (best_idx_d >= 0) && !best_th_d[31] &&
                          (best_dist_d <= {32'b0, best_th_d});
          empty_d       = 1'b0;
        end
      end

      FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      class_q       <= '0;
      x_q           <= '0;
      n_q           <= '0;
      idx_q         <= '0;
      best_dist_q   <= DIST_MAX;
      second_dist_q <= DIST_MAX;
      best_idx_q    <= -32'sd1;
      second_idx_q  <= -32'sd1;
      best_th_q     <= '0;
      winner_q      <= -32'sd1;
      runner_q      <= -32'sd1;
      winner_dist_q <= DIST_MAX;
      runner_dist_q <= DIST_MAX;
      within_th_q   <= 1'b0;
      empty_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      class_q       <= class_d;
      x_q           <= x_d;
      n_q           <= n_d;
      idx_q         <= idx_d;
      best_dist_q   <= best_dist_d;
      second_dist_q <= second_dist_d;
      best_idx_q    <= best_idx_d;
      second_idx_q  <= second_idx_d;
      best_th_q     <= best_th_d;
      winner_q      <= winner_d;
      runner_q      <= runner_d;
      winner_dist_q <= winner_dist_d;
      runner_dist_q <= runner_dist_d;
      within_th_q   <= within_th_d;
      empty_q       <= empty_d;
    end
  end

  assign winner_o      = winner_q;
  assign runner_o      = runner_q;
  assign winner_dist_o = winner_dist_q;
  assign runner_dist_o = runner_dist_q;
  assign within_th_o   = within_th_q;
  assign empty_o       = empty_q;

endmodule

// File: tb/tb_winner_search.sv
// Testbench for winner_search: directed corner cases plus randomized searches
// checked against a distance-ranking reference model.

module tb_winner_search;
  import winner_search_pkg::*;

  localparam int MAXN = 8;
  localparam int VL   = 4;
  localparam logic [63:0] ALL1 = '1;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic signed [31:0]  class_i;
  logic signed [31:0]  n_nodes_i;
  logic [VL-1:0][31:0] X_i;
  logic [VL-1:0][31:0] mem_W_i;
  logic signed [31:0]  mem_Th_i;
  logic signed [31:0]  mem_class_o;
  logic signed [31:0]  mem_node_o;
  RD_WR_T              mem_RD_WR_c;
  logic                mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c;
  logic                busy, done;
  logic signed [31:0]  winner_o, runner_o;
  logic [63:0]         winner_dist_o, runner_dist_o;
  logic                within_th_o, empty_o;

  int memW [MAXN][VL];
  int memTh [MAXN];
  int xv [VL];

  int checks_total  = 0;
  int checks_passed = 0;

  int          exp_n, exp_w, exp_r;
  logic [63:0] exp_wd, exp_rd;
  logic        exp_within, exp_empty;

  winner_search #(.MAX_NODES(MAXN), .VEC_LEN(VL)) dut (
    .clk(clk), .reset(reset), .start(start),
    .class_i(class_i), .n_nodes_i(n_nodes_i), .X_i(X_i),
    .mem_W_i(mem_W_i), .mem_Th_i(mem_Th_i),
    .mem_class_o(mem_class_o), .mem_node_o(mem_node_o), .mem_RD_WR_c(mem_RD_WR_c),
    .mem_X_c(mem_X_c), .mem_C_c(mem_C_c), .mem_W_c(mem_W_c), .mem_T_c(mem_T_c), .mem_M_c(mem_M_c),
    .busy(busy), .done(done),
    .winner_o(winner_o), .runner_o(runner_o),
    .winner_dist_o(winner_dist_o), .runner_dist_o(runner_dist_o),
    .within_th_o(within_th_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read of the addressed node.
  always_comb begin
    for (int k = 0; k < VL; k++) mem_W_i[k] = memW[mem_node_o[2:0]][k];
    mem_Th_i = memTh[mem_node_o[2:0]];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_total++;
    assert (got === exp) checks_passed++;
    else $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [63:0] distOf(input int n);
    logic [63:0] acc, mag, sq;
    longint dd;
    acc = '0;
    for (int k = 0; k < VL; k++) begin
      dd  = longint'(xv[k]) - longint'(memW[n][k]);
      mag = (dd < 0) ? 64'(-dd) : 64'(dd);
      sq  = mag * mag;
      if (acc > ALL1 - sq) acc = ALL1;
      else acc = acc + sq;
    end
    return acc;
  endfunction

  // Reference: winner is the first node with the smallest distance below the
  // all-ones ceiling; runner is the same search over the remaining nodes.
  task automatic modelExpect(input int n_req);
    logic [63:0] d [MAXN];
    exp_n = (n_req < 0) ? 0 : ((n_req > MAXN) ? MAXN : n_req);
    exp_w = -1; exp_wd = ALL1; exp_r = -1; exp_rd = ALL1;
    for (int i = 0; i < exp_n; i++) d[i] = distOf(i);
    for (int i = 0; i < exp_n; i++) if (d[i] < exp_wd) begin exp_w = i; exp_wd = d[i]; end
    for (int i = 0; i < exp_n; i++) if (i != exp_w && d[i] < exp_rd) begin exp_r = i; exp_rd = d[i]; end
    exp_within = 1'b0;
    if (exp_w >= 0) exp_within = (memTh[exp_w] >= 0) && (exp_wd <= 64'(memTh[exp_w]));
    exp_empty = (exp_n == 0);
  endtask

  task automatic applyStimulus(input int cls, input int n);
    class_i   = cls;
    n_nodes_i = n;
    for (int k = 0; k < VL; k++) X_i[k] = xv[k];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".busy"}, 64'(busy), 64'(0));
    checkOutput({tag, ".done"}, 64'(done), 64'(0));
    checkOutput({tag, ".winner"}, winner_o, -1);
    checkOutput({tag, ".runner"}, runner_o, -1);
    checkOutput({tag, ".wdist"}, winner_dist_o, ALL1);
    checkOutput({tag, ".rdist"}, runner_dist_o, ALL1);
    checkOutput({tag, ".within"}, 64'(within_th_o), 64'(0));
    checkOutput({tag, ".empty"}, 64'(empty_o), 64'(0));
    checkOutput({tag, ".enables"}, 64'({mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c}), 64'(0));
    checkOutput({tag, ".addr"}, {mem_class_o, mem_node_o}, 64'(0));
  endtask

  task automatic runSearch(input string tag, input int cls, input int n, input bit perturb);
    int  cycles;
    bit  seen, mem_ok, rw_ok;
    modelExpect(n);
    applyStimulus(cls, n);
    cycles = 0; seen = 0; mem_ok = 1; rw_ok = 1;
    while (!seen && cycles < 3 * MAXN + 10) begin
      cycles++;
      if (mem_RD_WR_c !== READ) rw_ok = 0;
      if (cycles <= exp_n) begin
        if (!(mem_W_c === 1'b1 && mem_T_c === 1'b1 && mem_X_c === 1'b0 && mem_C_c === 1'b0 &&
              mem_M_c === 1'b0 && mem_node_o === cycles - 1 && mem_class_o === cls && busy === 1'b1))
          mem_ok = 0;
      end else if ({mem_X_c, mem_C_c, mem_W_c, mem_T_c, mem_M_c} !== 5'b0) begin
        mem_ok = 0;
      end
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        if (perturb) begin
          for (int k = 0; k < VL; k++) X_i[k] = $urandom;
          class_i = $urandom;
          start   = 1'b1;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    checkOutput({tag, ".latency"}, 64'(cycles), 64'(exp_n + 1));
    checkOutput({tag, ".winner"}, winner_o, exp_w);
    checkOutput({tag, ".runner"}, runner_o, exp_r);
    checkOutput({tag, ".wdist"}, winner_dist_o, exp_wd);
    checkOutput({tag, ".rdist"}, runner_dist_o, exp_rd);
    checkOutput({tag, ".within"}, 64'(within_th_o), 64'(exp_within));
    checkOutput({tag, ".empty"}, 64'(empty_o), 64'(exp_empty));
    checkOutput({tag, ".mem"}, 64'(mem_ok), 64'(1));
    checkOutput({tag, ".rdwr"}, 64'(rw_ok), 64'(1));
    @(negedge clk);
  endtask

  task automatic randomMem(input int span);
    for (int i = 0; i < MAXN; i++) begin
      for (int k = 0; k < VL; k++) memW[i][k] = int'($urandom_range(0, 2 * span)) - span;
      memTh[i] = int'($urandom_range(0, 300)) - 20;
    end
    for (int k = 0; k < VL; k++) xv[k] = int'($urandom_range(0, 2 * span)) - span;
  endtask

  // Overall watchdog in case a wait is never satisfied.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed and randomized sequence.
  initial begin
    int done_cnt, first_done, second_done;
    bit rw_ok;
    reset = 1'b1; start = 1'b0; class_i = 0; n_nodes_i = 0; X_i = '0;
    for (int i = 0; i < MAXN; i++) begin
      memTh[i] = 0;
      for (int k = 0; k < VL; k++) memW[i][k] = 0;
    end
    for (int k = 0; k < VL; k++) xv[k] = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    checkReset("reset");

    // Worked example: class 2, three nodes
    for (int k = 0; k < VL; k++) xv[k] = 0;
    memW[0] = '{3, 0, 0, 0}; memW[1] = '{1, 1, 0, 0}; memW[2] = '{2, 0, 0, 0};
    memTh[0] = 0; memTh[1] = 2; memTh[2] = 0;
    runSearch("ex3", 2, 3, 1'b0);
    @(negedge clk); @(negedge clk);
    checkOutput("ex3.hold_winner", winner_o, 1);
    checkOutput("ex3.hold_wdist", winner_dist_o, 64'd2);
    checkOutput("ex3.hold_runner", runner_o, 2);
    checkOutput("ex3.hold_rdist", runner_dist_o, 64'd4);
    checkOutput("ex3.hold_within", 64'(within_th_o), 64'(1));

    // Empty class, zero and negative counts
    runSearch("n0", 5, 0, 1'b0);
    checkOutput("n0.empty_const", 64'(empty_o), 64'(1));
    runSearch("nneg", 5, -3, 1'b0);

    // Tie: identical nodes, lowest index wins
    memW[0] = '{1, 1, 1, 1}; memW[1] = '{1, 1, 1, 1};
    runSearch("tie", 1, 2, 1'b0);
    checkOutput("tie.winner_const", winner_o, 0);
    checkOutput("tie.runner_const", runner_o, 1);
    checkOutput("tie.dist_const", runner_dist_o, 64'd4);

    // Single node: no runner
    runSearch("n1", 1, 1, 1'b0);
    checkOutput("n1.runner_const", runner_o, -1);

    // Saturation and near-saturation
    for (int k = 0; k < VL; k++) begin
      xv[k] = 32'h7fff_ffff; memW[0][k] = 32'h8000_0000; memW[1][k] = 32'h7fff_ffff;
    end
    memW[1][0] = 32'h8000_0000;
    runSearch("sat1", 3, 1, 1'b0);
    checkOutput("sat1.wdist_const", winner_dist_o, ALL1);
    runSearch("sat2", 3, 2, 1'b0);
    checkOutput("sat2.wdist_const", winner_dist_o, 64'hFFFF_FFFE_0000_0001);

    // Count above MAX_NODES is capped, with input churn during the scan
    randomMem(20);
    runSearch("clamp", 7, 20, 1'b1);

    // Randomized searches
    for (int t = 0; t < 20; t++) begin
      randomMem((t % 4 == 3) ? 2000000000 : 6);
      runSearch($sformatf("rnd%0d", t), int'($urandom_range(0, 9)),
                int'($urandom_range(0, 12)) - 2, t[0]);
    end

    // Reset during scan aborts the search
    randomMem(10);
    applyStimulus(4, 8);
    done_cnt = 0;
    for (int c = 1; c < 3; c++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkReset("abort");
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) done_cnt++;
      @(negedge clk);
    end
    checkOutput("abort.no_done", 64'(done_cnt), 64'(0));
    runSearch("after_abort", 4, 8, 1'b0);

    // Start held high: one done every 7 cycles for N=5
    randomMem(8);
    modelExpect(5);
    class_i = 6; n_nodes_i = 5;
    for (int k = 0; k < VL; k++) X_i[k] = xv[k];
    start = 1'b1;
    done_cnt = 0; first_done = 0; second_done = 0; rw_ok = 1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (mem_RD_WR_c !== READ) rw_ok = 0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
      end
    end
    start = 1'b0;
    checkOutput("burst.count", 64'(done_cnt), 64'(3));
    checkOutput("burst.first", 64'(first_done), 64'(6));
    checkOutput("burst.period", 64'(second_done - first_done), 64'(7));
    checkOutput("burst.rdwr", 64'(rw_ok), 64'(1));
    checkOutput("burst.winner", winner_o, exp_w);
    checkOutput("burst.wdist", winner_dist_o, exp_wd);
    @(negedge clk); @(negedge clk);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
